// File: rtl/batch_eval_scheduler_if.sv
// Handshake bundle between the host/evaluator side and batch_eval_scheduler.
// The scheduler connects through the slave modport; the host side uses master.
interface batch_eval_scheduler_if #(
  parameter int MAX_BOARDS = 7,
  parameter int SLOT_BITS  = 88,
  parameter int BOARD_BITS = 84,
  parameter int SCORE_W    = 32
);
  logic                              start;
  logic [7:0]                        is_max_or_min;
  logic [7:0]                        batch_size;
  logic [SLOT_BITS*MAX_BOARDS-1:0]   batch;
  logic [BOARD_BITS-1:0]             eval_board;
  logic                              eval_start;
  logic                              eval_valid;
  logic signed [SCORE_W-1:0]         eval_score;
  logic                              busy;
  logic signed [SCORE_W-1:0]         final_evaluation;
  logic [2:0]                        best_index;
  logic                              final_evaluation_stable;
  logic                              eval_timeout;

  modport slave (
    input  start, is_max_or_min, batch_size, batch, eval_valid, eval_score,
    output eval_board, eval_start, busy, final_evaluation, best_index,
           final_evaluation_stable, eval_timeout
  );

  modport master (
    output start, is_max_or_min, batch_size, batch, eval_valid, eval_score,
    input  eval_board, eval_start, busy, final_evaluation, best_index,
           final_evaluation_stable, eval_timeout
  );
endinterface

// File: rtl/batch_eval_scheduler.sv
// Issues each board of a latched batch to one shared evaluator, waits for its
// score (with timeout) and reduces the scores to a single max/min result.
module batch_eval_scheduler #(
  parameter int MAX_BOARDS     = 7,
  parameter int SLOT_BITS      = 88,
  parameter int BOARD_BITS     = 84,
  parameter int SCORE_W        = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    batch_eval_scheduler_reset,
  batch_eval_scheduler_if.slave   bus
);

  localparam int BATCH_BITS = SLOT_BITS * MAX_BOARDS;
  localparam int BASE_W     = $clog2(BATCH_BITS);
  localparam int TMR_W      = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ACCUM = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                    r_state;
  logic                      r_mode;
  logic [2:0]                r_n;
  logic [BATCH_BITS-1:0]     r_batch;
  logic [2:0]                r_slot;
  logic [TMR_W-1:0]          r_timer;
  logic signed [SCORE_W-1:0] r_score;
  logic                      r_skip;
  logic                      r_have_best;
  logic signed [SCORE_W-1:0] r_best;
  logic [2:0]                r_best_idx;

  logic [BOARD_BITS-1:0]     r_eval_board;
  logic                      r_eval_start;
  logic                      r_busy;
  logic signed [SCORE_W-1:0] r_final;
  logic [2:0]                r_best_index;
  logic                      r_stable;
  logic                      r_timeout;

  logic [2:0]                w_n_clamped;
  logic [BASE_W-1:0]         w_slot_base;
  logic [BOARD_BITS-1:0]     w_slot_board;
  logic                      w_unused_mode_bits;

  // Strict comparison keeps the earlier (lower-index) slot on ties.
  function automatic logic f_better(input logic mode,
                                    input logic signed [SCORE_W-1:0] cand,
                                    input logic signed [SCORE_W-1:0] best);
    return mode ? (cand > best) : (cand < best);
  endfunction

  assign w_n_clamped  = (bus.batch_size > 8'(MAX_BOARDS)) ? 3'(MAX_BOARDS)
                                                          : bus.batch_size[2:0];
  assign w_slot_base  = BASE_W'(SLOT_BITS) * BASE_W'(r_slot);
  assign w_slot_board = r_batch[w_slot_base +: BOARD_BITS];
  assign w_unused_mode_bits = ^bus.is_max_or_min[7:1];

  // Batch sequencing FSM with all result/handshake outputs registered.
  always_ff @(posedge clk or negedge batch_eval_scheduler_reset) begin
    if (!batch_eval_scheduler_reset) begin
      r_state      <= S_IDLE;
      r_mode       <= 1'b0;
      r_n          <= 3'd0;
      r_batch      <= '0;
      r_slot       <= 3'd0;
      r_timer      <= '0;
      r_score      <= '0;
      r_skip       <= 1'b0;
      r_have_best  <= 1'b0;
      r_best       <= '0;
      r_best_idx   <= 3'd0;
      r_eval_board <= '0;
      r_eval_start <= 1'b0;
      r_busy       <= 1'b0;
      r_final      <= '0;
      r_best_index <= 3'd0;
      r_stable     <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_eval_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mode      <= bus.is_max_or_min[0];
            r_n         <= w_n_clamped;
            r_batch     <= bus.batch;
            r_slot      <= 3'd0;
            r_stable    <= 1'b0;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b1;
            r_have_best <= 1'b0;
            r_best      <= '0;
            r_best_idx  <= 3'd0;
            r_state     <= (w_n_clamped == 3'd0) ? S_DONE : S_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_eval_board <= w_slot_board;
          r_eval_start <= 1'b1;
          r_timer      <= '0;
          r_state      <= S_WAIT;
        end
        S_WAIT: begin
          // A score arriving on the timeout cycle still counts.
          if (bus.eval_valid) begin
            r_score <= bus.eval_score;
            r_skip  <= 1'b0;
            r_state <= S_ACCUM;
          end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            r_timeout <= 1'b1;
            r_skip    <= 1'b1;
            r_state   <= S_ACCUM;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_ACCUM: begin
          if (!r_skip && (!r_have_best || f_better(r_mode, r_score, r_best))) begin
            r_best      <= r_score;
            r_best_idx  <= r_slot;
            r_have_best <= 1'b1;
          end else begin
            r_have_best <= r_have_best;
          end
          if (r_slot == 3'(r_n - 3'd1)) begin
            r_state <= S_DONE;
          end else begin
            r_slot  <= r_slot + 3'd1;
            r_state <= S_ISSUE;
          end
        end
        S_DONE: begin
          r_final      <= r_best;
          r_best_index <= r_best_idx;
          r_stable     <= 1'b1;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.eval_board              = r_eval_board;
  assign bus.eval_start              = r_eval_start;
  assign bus.busy                    = r_busy;
  assign bus.final_evaluation        = r_final;
  assign bus.best_index              = r_best_index;
  assign bus.final_evaluation_stable = r_stable;
  assign bus.eval_timeout            = r_timeout;

endmodule

// File: tb/tb_batch_eval_scheduler.sv
// Bench for batch_eval_scheduler: directed vector table, hand-written corner
// sequences and random batches checked against a behavioural reduction model.
module tb_batch_eval_scheduler;
  localparam int NB = 7;
  localparam int SB = 88;
  localparam int BB = 84;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  batch_eval_scheduler_if bif();

  batch_eval_scheduler dut (
    .clk                        (clk),
    .batch_eval_scheduler_reset (rst_n),
    .bus                        (bif)
  );

  int total = 0;
  int bad   = 0;

  logic [SB*NB-1:0]  tb_batch;
  logic signed [31:0] ev_score [NB];
  int                 ev_dly   [NB];   // -1: evaluator never answers
  int                 ev_cnt  = 0;
  int                 ev_base = 0;
  logic [BB-1:0]      seen_board [8];

  typedef struct packed {
    logic              mode;
    logic [7:0]        bsize;
    logic [6:0][31:0]  score;
    logic [6:0][15:0]  dly;     // 16'hFFFF: silent
    logic [31:0]       exp_f;
    logic [2:0]        exp_idx;
    logic              exp_to;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  function automatic logic [SB*NB-1:0] rand_batch();
    logic [SB*NB-1:0] r;
    r = '0;
    for (int i = 0; i < 19; i++) r[32*i +: 32] = $urandom;
    r[SB*NB-1:608] = 8'($urandom);
    return r;
  endfunction

  // Reference: clamp count, skip silent slots, keep first strictly-better score.
  task automatic model(input bit mode, input int bs, output logic signed [31:0] f,
                       output int idx, output bit to, output int n);
    bit found;
    n = (bs > NB) ? NB : bs;
    f = 0; idx = 0; to = 1'b0; found = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (ev_dly[i] < 0) to = 1'b1;
      else if (!found || (mode ? (ev_score[i] > f) : (ev_score[i] < f))) begin
        f = ev_score[i]; idx = i; found = 1'b1;
      end
    end
  endtask

  // Evaluator stand-in: answers each eval_start after its programmed delay.
  initial begin : evaluator
    int k;
    bif.eval_valid = 1'b0;
    bif.eval_score = '0;
    forever begin
      @(negedge clk);
      if (bif.eval_start) begin
        k = ev_cnt - ev_base;
        if (k >= 0 && k < 8) seen_board[k] = bif.eval_board;
        ev_cnt++;
        if (k >= 0 && k < NB && ev_dly[k] >= 0) begin
          repeat (ev_dly[k]) @(negedge clk);
          bif.eval_valid = 1'b1;
          bif.eval_score = ev_score[k];
          @(negedge clk);
          bif.eval_valid = 1'b0;
          bif.eval_score = 32'($urandom);
        end
      end
    end
  end

  task automatic kick(input bit mode, input int bs);
    ev_base = ev_cnt;
    bif.is_max_or_min = {7'($urandom), mode};
    bif.batch_size    = 8'(bs);
    bif.batch         = tb_batch;
    bif.start         = 1'b1;
    @(negedge clk);
    bif.start         = 1'b0;
    bif.batch         = rand_batch();
    bif.batch_size    = 8'($urandom);
    bif.is_max_or_min = 8'($urandom);
    chk("busy after start", longint'(bif.busy), 1);
  endtask

  task automatic wait_done(input string nm, input logic signed [31:0] ef,
                           input int eidx, input bit eto, input int en);
    int c;
    int mism;
    c = 0;
    while (!bif.final_evaluation_stable && c < 40000) begin
      @(negedge clk);
      c++;
    end
    chk({nm, " stable"},  longint'(bif.final_evaluation_stable), 1);
    chk({nm, " final"},   longint'(bif.final_evaluation), longint'(ef));
    chk({nm, " index"},   longint'(bif.best_index), longint'(eidx));
    chk({nm, " timeout"}, longint'(bif.eval_timeout), longint'(eto));
    chk({nm, " busy"},    longint'(bif.busy), 0);
    chk({nm, " pulses"},  longint'(ev_cnt - ev_base), longint'(en));
    mism = 0;
    for (int i = 0; i < en; i++)
      if (seen_board[i] !== tb_batch[SB*i +: BB]) mism++;
    chk({nm, " boards"}, longint'(mism), 0);
  endtask

  function automatic vec_t base_vec(input bit mode, input int bs);
    vec_t v;
    v = '0;
    v.mode  = mode;
    v.bsize = 8'(bs);
    for (int i = 0; i < NB; i++) v.dly[i] = 16'd2;
    return v;
  endfunction

  initial begin : main
    logic signed [31:0] ef;
    int eidx, en, c, k0, bs;
    bit eto, md;

    rst_n = 1'b0;
    bif.start = 1'b0;
    bif.is_max_or_min = 8'd0;
    bif.batch_size = 8'd0;
    bif.batch = '0;
    for (int i = 0; i < NB; i++) begin ev_score[i] = 0; ev_dly[i] = 2; end

    // Directed vectors with hand-derived expectations.
    vecs[0] = base_vec(1'b1, 1); vecs[0].score[0] = 32'sd5; vecs[0].dly[0] = 16'd10;
    vecs[0].exp_f = 32'sd5; vecs[0].exp_idx = 3'd0; vecs[0].exp_to = 1'b0;
    vecs[1] = base_vec(1'b1, 3);
    vecs[1].score[0] = -32'sd3; vecs[1].score[1] = 32'sd10; vecs[1].score[2] = 32'sd10;
    vecs[1].exp_f = 32'sd10; vecs[1].exp_idx = 3'd1; vecs[1].exp_to = 1'b0;
    vecs[2] = vecs[1]; vecs[2].mode = 1'b0;
    vecs[2].exp_f = -32'sd3; vecs[2].exp_idx = 3'd0;
    vecs[3] = base_vec(1'b1, 0);
    vecs[3].exp_f = 32'sd0; vecs[3].exp_idx = 3'd0; vecs[3].exp_to = 1'b0;
    vecs[4] = base_vec(1'b1, 9);
    for (int i = 0; i < 6; i++) vecs[4].score[i] = 32'(i + 1);
    vecs[4].score[6] = 32'sd100;
    vecs[4].exp_f = 32'sd100; vecs[4].exp_idx = 3'd6; vecs[4].exp_to = 1'b0;
    vecs[5] = base_vec(1'b1, 2); vecs[5].dly[0] = 16'hFFFF;
    vecs[5].score[0] = 32'sd99; vecs[5].score[1] = 32'sd7;
    vecs[5].exp_f = 32'sd7; vecs[5].exp_idx = 3'd1; vecs[5].exp_to = 1'b1;
    vecs[6] = base_vec(1'b1, 2); vecs[6].dly[0] = 16'hFFFF; vecs[6].dly[1] = 16'hFFFF;
    vecs[6].score[0] = 32'sd3; vecs[6].score[1] = 32'sd4;
    vecs[6].exp_f = 32'sd0; vecs[6].exp_idx = 3'd0; vecs[6].exp_to = 1'b1;
    vecs[7] = base_vec(1'b0, 5);
    vecs[7].score[0] = 32'sd4;  vecs[7].score[1] = -32'sd8; vecs[7].score[2] = 32'sd2;
    vecs[7].score[3] = -32'sd8; vecs[7].score[4] = 32'sd9;
    vecs[7].exp_f = -32'sd8; vecs[7].exp_idx = 3'd1; vecs[7].exp_to = 1'b0;

    #1;
    chk("reset busy",   longint'(bif.busy), 0);
    chk("reset final",  longint'(bif.final_evaluation), 0);
    chk("reset stable", longint'(bif.final_evaluation_stable), 0);
    chk("reset estart", longint'(bif.eval_start), 0);
    chk("reset tmo",    longint'(bif.eval_timeout), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      tb_batch = rand_batch();
      for (int i = 0; i < NB; i++) begin
        ev_score[i] = $signed(vecs[v].score[i]);
        ev_dly[i]   = (vecs[v].dly[i] == 16'hFFFF) ? -1 : int'(vecs[v].dly[i]);
      end
      bs = int'(vecs[v].bsize);
      kick(vecs[v].mode, bs);
      wait_done($sformatf("vec%0d", v), $signed(vecs[v].exp_f), int'(vecs[v].exp_idx),
                vecs[v].exp_to, (bs > NB) ? NB : bs);
    end

    // Empty batch: stable exactly two cycles after start, result cleared.
    tb_batch = rand_batch();
    kick(1'b1, 0);
    chk("n0 stable early", longint'(bif.final_evaluation_stable), 0);
    @(negedge clk);
    chk("n0 stable", longint'(bif.final_evaluation_stable), 1);
    chk("n0 final",  longint'(bif.final_evaluation), 0);
    chk("n0 pulses", longint'(ev_cnt - ev_base), 0);

    // Second start while waiting on slot 0 must be ignored.
    tb_batch = rand_batch();
    for (int i = 0; i < NB; i++) begin
      ev_score[i] = int'($urandom_range(0, 20)) - 10;
      ev_dly[i] = 25;
    end
    model(1'b0, 3, ef, eidx, eto, en);
    kick(1'b0, 3);
    c = 0;
    while ((ev_cnt - ev_base) < 1 && c < 100) begin @(negedge clk); c++; end
    repeat (3) @(negedge clk);
    bif.batch_size = 8'd7;
    bif.is_max_or_min = 8'h01;
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    wait_done("restart", ef, eidx, eto, en);

    // Random batches against the reference model.
    for (int r = 0; r < 20; r++) begin
      md = 1'($urandom_range(0, 1));
      bs = int'($urandom_range(0, 12));
      for (int i = 0; i < NB; i++) begin
        ev_score[i] = int'($urandom_range(0, 20)) - 10;
        ev_dly[i] = int'($urandom_range(0, 12));
      end
      model(md, bs, ef, eidx, eto, en);
      tb_batch = rand_batch();
      kick(md, bs);
      wait_done($sformatf("rand%0d", r), ef, eidx, eto, en);
    end

    // Reset in the middle of slot 2, then a clean batch with a stale answer pending.
    tb_batch = rand_batch();
    for (int i = 0; i < NB; i++) begin ev_score[i] = 32'sd50 + i; ev_dly[i] = 20; end
    kick(1'b1, 4);
    c = 0;
    while ((ev_cnt - ev_base) < 3 && c < 500) begin @(negedge clk); c++; end
    chk("midrst reached slot2", longint'((ev_cnt - ev_base) >= 3), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy",   longint'(bif.busy), 0);
    chk("midrst estart", longint'(bif.eval_start), 0);
    chk("midrst board",  longint'(bif.eval_board == '0), 1);
    chk("midrst final",  longint'(bif.final_evaluation), 0);
    chk("midrst index",  longint'(bif.best_index), 0);
    chk("midrst stable", longint'(bif.final_evaluation_stable), 0);
    chk("midrst tmo",    longint'(bif.eval_timeout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    k0 = ev_cnt;
    repeat (40) @(negedge clk);
    chk("postrst idle pulses", longint'(ev_cnt - k0), 0);
    chk("postrst busy", longint'(bif.busy), 0);
    tb_batch = rand_batch();
    for (int i = 0; i < NB; i++) begin
      ev_score[i] = int'($urandom_range(0, 20)) - 10;
      ev_dly[i] = int'($urandom_range(0, 6));
    end
    model(1'b0, 5, ef, eidx, eto, en);
    kick(1'b0, 5);
    wait_done("postrst", ef, eidx, eto, en);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
